line_scanout: RTL and testbench



---
 rtl/line_scanout_pkg.sv | 32 +++
 rtl/line_scanout_if.sv | 32 +++
 rtl/line_scanout_line_buffer.sv | 32 +++
 rtl/line_scanout.sv | 130 +++++++++++++
 tb/tb_line_scanout.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/line_scanout_pkg.sv
// Shared types and constants for the double-buffered line scanout.
// Geometry matches 640x480 VGA with a 525-line frame.
package line_scanout_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

    typedef logic [23:0] rgb_t;
    typedef logic [9:0]  coord_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_READY
    } scan_state_e;

    localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
    localparam coord_t H_LAST_C = coord_t'(H_ACTIVE - 1);
    localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);

    // (y + k) mod V_TOTAL for y < V_TOTAL and small k
    function automatic coord_t line_add(coord_t y, coord_t k);
        logic [10:0] s;
        s = {1'b0, y} + {1'b0, k};
        if (s >= 11'(V_TOTAL)) begin
            s = s - 11'(V_TOTAL);
        end
        return s[9:0];
    endfunction

endpackage

// File: rtl/line_scanout_if.sv
// Signal bundle between the VGA timing / renderer side and the scanout.
// master = timing + renderer, slave = line_scanout.
interface line_scanout_if;
    import line_scanout_pkg::*;

    logic   pixel_en;
    coord_t draw_x;
    coord_t draw_y;
    logic   blank_n;
    logic   wr_en;
    coord_t wr_addr;
    rgb_t   wr_data;
    logic   line_req;
    coord_t req_line;
    logic   line_done;
    rgb_t   rgb_out;
    logic   blank_n_out;
    logic   underrun;

    modport master (
        output pixel_en, draw_x, draw_y, blank_n,
        output wr_en, wr_addr, wr_data, line_done,
        input  line_req, req_line, rgb_out, blank_n_out, underrun
    );

    modport slave (
        input  pixel_en, draw_x, draw_y, blank_n,
        input  wr_en, wr_addr, wr_data, line_done,
        output line_req, req_line, rgb_out, blank_n_out, underrun
    );

endinterface

// File: rtl/line_scanout_line_buffer.sv
// Single-port 640x24 line RAM with registered read data.
module line_buffer
    import line_scanout_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   we_i,
    input  coord_t addr_i,
    input  rgb_t   wdata_i,
    output rgb_t   rdata_o
);

    rgb_t mem_q [H_ACTIVE];
    rgb_t rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_scanout.sv
// Ping-pong line buffer: front bank scans out, back bank is filled by the
// renderer; banks swap at end of line when the back line is complete.
module line_scanout
    import line_scanout_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    line_scanout_if.slave bus
);

    scan_state_e state_q, state_d;
    logic        bank_sel_q, bank_sel_d;
    coord_t      req_line_q, req_line_d;
    logic        underrun_q, underrun_d;
    logic        started_q;

    logic        vld1_q, blank1_q, sel1_q;
    rgb_t        rgb_q;
    logic        blank_out_q;

    logic        line_req, back_done, done_now;
    logic        eol, wr_ok;
    coord_t      nxt, nr, rd_addr;
    rgb_t        front_rdata;

    rgb_t        rdata [2];
    coord_t      addr  [2];
    logic        we    [2];

    assign line_req  = (state_q == ST_REQ);
    assign back_done = (state_q == ST_READY);
    assign done_now  = bus.line_done && line_req;

    assign eol = bus.pixel_en && (bus.draw_x == H_LAST_C);
    assign nxt = line_add(bus.draw_y, 10'd1);
    assign nr  = line_add(bus.draw_y, 10'd2);

    assign rd_addr = (bus.draw_x < H_ACT_C) ? bus.draw_x : '0;
    assign wr_ok   = bus.wr_en && (bus.wr_addr < H_ACT_C);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic front;
        assign front   = (bank_sel_q == 1'(b));
        assign addr[b] = front ? rd_addr : bus.wr_addr;
        assign we[b]   = wr_ok && !front;

        line_buffer u_buf (
            .clk     (clk),
            .reset_n (reset_n),
            .we_i    (we[b]),
            .addr_i  (addr[b]),
            .wdata_i (bus.wr_data),
            .rdata_o (rdata[b])
        );
    end

    // bank seen at read time, so a swap on the EOL pixel cannot retarget it
    assign front_rdata = sel1_q ? rdata[1] : rdata[0];

    always_comb begin
        state_d    = state_q;
        bank_sel_d = bank_sel_q;
        req_line_d = req_line_q;
        underrun_d = underrun_q;

        if (done_now) begin
            state_d = ST_READY;
        end

        if (eol && (nxt < V_ACT_C)) begin
            if (back_done || done_now) begin
                bank_sel_d = ~bank_sel_q;
                state_d    = ST_IDLE;
            end else begin
                underrun_d = 1'b1;
            end
        end

        if (!started_q) begin
            state_d    = ST_REQ;
            req_line_d = '0;
        end else if (eol && (nr < V_ACT_C) && (state_d == ST_IDLE)) begin
            state_d    = ST_REQ;
            req_line_d = nr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bank_sel_q <= 1'b0;
            req_line_q <= '0;
            underrun_q <= 1'b0;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_sel_q <= bank_sel_d;
            req_line_q <= req_line_d;
            underrun_q <= underrun_d;
            started_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld1_q      <= 1'b0;
            blank1_q    <= 1'b0;
            sel1_q      <= 1'b0;
            rgb_q       <= '0;
            blank_out_q <= 1'b0;
        end else begin
            vld1_q <= bus.pixel_en;
            if (bus.pixel_en) begin
                blank1_q <= bus.blank_n;
                sel1_q   <= bank_sel_q;
            end
            if (vld1_q) begin
                blank_out_q <= blank1_q;
                rgb_q       <= blank1_q ? front_rdata : '0;
            end
        end
    end

    assign bus.line_req    = line_req;
    assign bus.req_line    = req_line_q;
    assign bus.rgb_out     = rgb_q;
    assign bus.blank_n_out = blank_out_q;
    assign bus.underrun    = underrun_q;

endmodule

// File: tb/tb_line_scanout.sv
// Directed bench for line_scanout: read-path vector table plus
// hand-written swap, underrun, frame-wrap and reset sequences.
module tb_line_scanout;
    import line_scanout_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    line_scanout_if bus ();

    line_scanout dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         x;
        logic       bn;
        logic [23:0] rgb;
        logic       bo;
    } vec_t;

    vec_t tbl [8];
    int n_chk = 0;
    int n_fail = 0;
    logic [23:0] last_rgb = '0;

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [23:0] d);
        bus.wr_en = 1'b1;
        bus.wr_addr = 10'(a);
        bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic done_pulse();
        bus.line_done = 1'b1;
        step();
        bus.line_done = 1'b0;
    endtask

    task automatic rd(input string nm, input int x, input int y, input logic bn,
                      input logic [23:0] exp, input logic bo);
        bus.pixel_en = 1'b1;
        bus.draw_x = 10'(x);
        bus.draw_y = 10'(y);
        bus.blank_n = bn;
        step();
        bus.pixel_en = 1'b0;
        chk({nm, "_lat"}, bus.rgb_out, last_rgb);
        step();
        chk(nm, bus.rgb_out, exp);
        chk({nm, "_bo"}, 24'(bus.blank_n_out), 24'(bo));
        step();
        chk({nm, "_hold"}, bus.rgb_out, exp);
        last_rgb = exp;
    endtask

    task automatic eol(input string nm, input int y, input logic done,
                       input logic bn, input logic [23:0] exp);
        bus.pixel_en = 1'b1;
        bus.draw_x = 10'd639;
        bus.draw_y = 10'(y);
        bus.blank_n = bn;
        bus.line_done = done;
        step();
        bus.pixel_en = 1'b0;
        bus.line_done = 1'b0;
        step();
        chk({nm, "_rgb"}, bus.rgb_out, exp);
        last_rgb = exp;
    endtask

    task automatic chk_req(input string nm, input logic req, input int line);
        chk({nm, "_req"}, 24'(bus.line_req), 24'(req));
        chk({nm, "_line"}, 24'(bus.req_line), 24'(line));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_req"}, 24'(bus.line_req), 24'd0);
        chk({nm, "_line"}, 24'(bus.req_line), 24'd0);
        chk({nm, "_rgb"}, bus.rgb_out, 24'd0);
        chk({nm, "_bo"}, 24'(bus.blank_n_out), 24'd0);
        chk({nm, "_ur"}, 24'(bus.underrun), 24'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{x: 0,   bn: 1'b1, rgb: 24'h0F0F0F, bo: 1'b1};
        tbl[1] = '{x: 1,   bn: 1'b1, rgb: 24'hFF0000, bo: 1'b1};
        tbl[2] = '{x: 5,   bn: 1'b1, rgb: 24'h123456, bo: 1'b1};
        tbl[3] = '{x: 5,   bn: 1'b0, rgb: 24'h000000, bo: 1'b0};
        tbl[4] = '{x: 638, bn: 1'b1, rgb: 24'hFF0000, bo: 1'b1};
        tbl[5] = '{x: 700, bn: 1'b1, rgb: 24'h0F0F0F, bo: 1'b1};
        tbl[6] = '{x: 320, bn: 1'b0, rgb: 24'h000000, bo: 1'b0};
        tbl[7] = '{x: 320, bn: 1'b1, rgb: 24'hFF0000, bo: 1'b1};

        bus.pixel_en = 1'b0;
        bus.draw_x = '0;
        bus.draw_y = '0;
        bus.blank_n = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.line_done = 1'b0;

        // reset and first request
        repeat (3) step();
        chk_all_zero("in_reset");
        reset_n = 1'b1;
        step();
        chk_req("rel", 1'b1, 0);
        chk("rel_rgb", bus.rgb_out, 24'd0);
        chk("rel_bo", 24'(bus.blank_n_out), 24'd0);
        chk("rel_ur", 24'(bus.underrun), 24'd0);

        // fill line 0 in back bank
        for (int a = 0; a < 640; a++) wr(a, 24'hFF0000);
        wr(0, 24'h0F0F0F);
        wr(5, 24'h123456);
        wr(639, 24'h00ABCD);
        wr(700, 24'hFFFFFF);
        chk_req("fill", 1'b1, 0);
        done_pulse();
        chk_req("done0", 1'b0, 0);

        eol("eol524", 524, 1'b0, 1'b0, 24'h0);
        chk_req("eol524", 1'b1, 1);
        chk("eol524_ur", 24'(bus.underrun), 24'd0);

        for (int i = 0; i < 8; i++)
            rd($sformatf("tbl%0d", i), tbl[i].x, 0, tbl[i].bn, tbl[i].rgb, tbl[i].bo);

        // line_done coincident with EOL
        wr(100, 24'h00FF00);
        eol("eol0_done", 0, 1'b1, 1'b1, 24'h00ABCD);
        chk_req("eol0_done", 1'b1, 2);
        chk("eol0_ur", 24'(bus.underrun), 24'd0);
        rd("l1_px100", 100, 1, 1'b1, 24'h00FF00, 1'b1);

        // underrun: line 10's data repeats on line 11
        wr(100, 24'h0000FF);
        done_pulse();
        eol("eol9", 9, 1'b0, 1'b0, 24'h0);
        chk_req("eol9", 1'b1, 11);
        rd("l10_px100", 100, 10, 1'b1, 24'h0000FF, 1'b1);
        wr(100, 24'hAAAAAA);
        eol("eol10", 10, 1'b0, 1'b0, 24'h0);
        chk("eol10_ur", 24'(bus.underrun), 24'd1);
        chk_req("eol10", 1'b1, 11);
        rd("l11_repeat", 100, 11, 1'b1, 24'h0000FF, 1'b1);
        done_pulse();
        chk_req("late_done", 1'b0, 11);
        eol("eol11", 11, 1'b0, 1'b0, 24'h0);
        chk_req("eol11", 1'b1, 13);
        chk("eol11_ur", 24'(bus.underrun), 24'd1);
        rd("l12_px100", 100, 12, 1'b1, 24'hAAAAAA, 1'b1);

        // out-of-range write and front-bank write gating
        wr(60, 24'h606060);
        wr(188, 24'hBCBCBC);
        wr(100, 24'h777777);
        wr(700, 24'h555555);
        rd("front_gate", 100, 12, 1'b1, 24'hAAAAAA, 1'b1);
        done_pulse();
        eol("eol12", 12, 1'b0, 1'b0, 24'h0);
        chk_req("eol12", 1'b1, 14);
        rd("l13_px60", 60, 13, 1'b1, 24'h606060, 1'b1);
        rd("l13_px188", 188, 13, 1'b1, 24'hBCBCBC, 1'b1);
        rd("l13_px100", 100, 13, 1'b1, 24'h777777, 1'b1);
        rd("l13_blank", 60, 13, 1'b0, 24'h000000, 1'b0);

        // vertical blanking and frame wrap
        done_pulse();
        eol("eol478", 478, 1'b0, 1'b0, 24'h0);
        chk_req("eol478", 1'b0, 14);
        eol("eol479", 479, 1'b0, 1'b0, 24'h0);
        chk_req("eol479", 1'b0, 14);
        done_pulse();
        eol("eol522", 522, 1'b0, 1'b0, 24'h0);
        chk_req("eol522", 1'b0, 14);
        eol("eol523", 523, 1'b0, 1'b0, 24'h0);
        chk_req("eol523", 1'b1, 0);
        done_pulse();
        eol("eol524b", 524, 1'b0, 1'b0, 24'h0);
        chk_req("eol524b", 1'b1, 1);
        rd("f2_px100", 100, 0, 1'b1, 24'h777777, 1'b1);

        // asynchronous reset mid-request
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        reset_n = 1'b1;
        step();
        chk_req("rerel", 1'b1, 0);
        chk("rerel_ur", 24'(bus.underrun), 24'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
